// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencing stages: operation codes, FSM states
// and the datapath width.
package alu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETTLE = 2'b01,
        S_HOLD   = 2'b10
    } state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// N/Z/C/O flag generation from an adder result. The b_msb input is the operand
// bit actually driven into the adder, so it is already inverted for subtraction.
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             o
);

    assign n = sum[WIDTH-1];
    assign z = (sum == '0);
    assign c = cout;
    assign o = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);

endmodule

// File: rtl/addsub_sequencer.sv
// Sequencer around the external combinational adder: accepts a request,
// drives the operands, waits SETTLE_CYCLES edges, then captures result and flags.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | ready for a request; operands latched on req_valid
// S_SETTLE | adder settling; counter runs down, sample when it reads 0
// S_HOLD   | response presented until rsp_ready; carry_flag updated then
module addsub_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_cin,
    input  logic [WIDTH-1:0] adder_s,
    input  logic             adder_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_n,
    output logic             rsp_z,
    output logic             rsp_c,
    output logic             rsp_o,
    output logic             carry_flag
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_o;

    alu_flag_gen u_flag_gen (
        .sum   (adder_s),
        .cout  (adder_cout),
        .a_msb (adder_a[WIDTH-1]),
        .b_msb (adder_b[WIDTH-1]),
        .n     (flag_n),
        .z     (flag_z),
        .c     (flag_c),
        .o     (flag_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            counter    <= '0;
            req_ready  <= 1'b1;
            adder_a    <= '0;
            adder_b    <= '0;
            adder_cin  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_n      <= 1'b0;
            rsp_z      <= 1'b0;
            rsp_c      <= 1'b0;
            rsp_o      <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        adder_a   <= req_a;
                        counter   <= CNT_LOAD;
                        req_ready <= 1'b0;
                        state     <= S_SETTLE;
                        case (req_op)
                            OP_ADD: begin adder_b <= req_b;  adder_cin <= 1'b0;       end
                            OP_SUB: begin adder_b <= ~req_b; adder_cin <= 1'b1;       end
                            OP_ADC: begin adder_b <= req_b;  adder_cin <= carry_flag; end
                            default: begin adder_b <= ~req_b; adder_cin <= carry_flag; end
                        endcase
                    end
                end
                S_SETTLE: begin
                    // adder_s/adder_cout are only looked at on this edge, so
                    // anything they do while settling never reaches an output.
                    if (counter == '0) begin
                        rsp_result <= adder_s;
                        rsp_n      <= flag_n;
                        rsp_z      <= flag_z;
                        rsp_c      <= flag_c;
                        rsp_o      <= flag_o;
                        rsp_valid  <= 1'b1;
                        state      <= S_HOLD;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (rsp_ready) begin
                        carry_flag <= rsp_c;
                        rsp_valid  <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed bench for addsub_sequencer driving a behavioural 32-bit adder,
// SETTLE_CYCLES = 4.
module tb_addsub_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] adder_a;
    logic [31:0] adder_b;
    logic        adder_cin;
    logic [31:0] adder_s;
    logic        adder_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_n;
    logic        rsp_z;
    logic        rsp_c;
    logic        rsp_o;
    logic        carry_flag;

    int checks = 0;
    int errors = 0;

    addsub_sequencer #(.SETTLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_s    (adder_s),
        .adder_cout (adder_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_n      (rsp_n),
        .rsp_z      (rsp_z),
        .rsp_c      (rsp_c),
        .rsp_o      (rsp_o),
        .carry_flag (carry_flag)
    );

    logic [32:0] full_sum;
    assign full_sum   = {1'b0, adder_a} + {1'b0, adder_b} + {32'd0, adder_cin};
    assign adder_s    = full_sum[31:0];
    assign adder_cout = full_sum[32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; returns edges from accept to rsp_valid.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'h1234_5678;
        req_op    = 2'b11;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] res,
                             input logic n, input logic z, input logic c, input logic o);
        chk({tag, "_result"}, rsp_result, res);
        chk({tag, "_nzco"}, {28'd0, rsp_n, rsp_z, rsp_c, rsp_o}, {28'd0, n, z, c, o});
    endtask

    task automatic handshake(input string tag, input logic exp_carry);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_low"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_carry_flag"}, {31'd0, carry_flag}, {31'd0, exp_carry});
    endtask

    initial begin
        int lat;
        logic [31:0] held_result;
        logic [31:0] held_a;
        logic        saw_valid;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_result", rsp_result, 32'd0);
        chk("reset_adder", {adder_a ^ adder_b, 31'd0, adder_cin}, 64'd0);
        chk("reset_carry", {31'd0, carry_flag}, 32'd0);

        run_op(2'b00, 32'd1, 32'd1, lat);
        chk("add_latency", lat, 32'd4);
        check_rsp("add", 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
        handshake("add", 1'b0);

        run_op(2'b01, 32'd0, 32'd1, lat);
        chk("sub_latency", lat, 32'd4);
        check_rsp("sub", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        handshake("sub", 1'b0);

        run_op(2'b00, 32'd3, 32'hFFFF_FFFF, lat);
        check_rsp("add_carry", 32'h0000_0002, 1'b0, 1'b0, 1'b1, 1'b0);
        handshake("add_carry", 1'b1);

        run_op(2'b10, 32'd0, 32'd0, lat);
        chk("adc_cin", {31'd0, adder_cin}, 32'd1);
        check_rsp("adc", 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        handshake("adc", 1'b0);

        run_op(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, lat);
        check_rsp("ovf", 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        handshake("ovf", 1'b0);

        run_op(2'b01, 32'd5, 32'd5, lat);
        chk("sub_zero_adder_b", adder_b, 32'hFFFF_FFFA);
        check_rsp("sub_zero", 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        held_result = rsp_result;
        held_a      = adder_a;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold_result", rsp_result, held_result);
            chk("hold_adder_a", adder_a, held_a);
            chk("hold_valid_ready", {30'd0, rsp_valid, req_ready}, 32'd2);
        end
        handshake("sub_zero", 1'b1);

        // Reset during SETTLE abandons the operation and clears carry_flag.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'h0000_0010;
        req_b     = 32'h0000_0020;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_carry", {31'd0, carry_flag}, 32'd0);
        chk("midrst_adder_a", adder_a, 32'd0);
        chk("midrst_adder_b", adder_b, 32'd0);
        chk("midrst_adder_cin", {31'd0, adder_cin}, 32'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) saw_valid = 1'b1;
        end
        chk("midrst_no_rsp", {31'd0, saw_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
